// File: rtl/issue_scheduler_if.sv
// Issue scheduler bus: rename-side allocation, completion wakeups,
// functional-unit stalls and the registered issue/occupancy outputs.
interface issue_scheduler_if #(
    parameter int RS_DEPTH = 16
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    // Allocation from rename, two slots per cycle (slot 0 older)
    logic [1:0]         alloc_valid;
    logic [1:0]         alloc_is_mem;
    logic [11:0]        alloc_rd;
    logic [23:0]        alloc_src_tag;
    logic [3:0]         alloc_src_rdy;
    logic               alloc_ready;

    // Completion broadcasts, one per unit (ALU0, ALU1, MEM)
    logic [2:0]         wakeup_valid;
    logic [17:0]        wakeup_tag;

    // Per-unit backpressure
    logic [2:0]         fu_stall;

    // Issue outputs, one lane per unit
    logic [2:0]         issue_valid;
    logic [3*IDX_W-1:0] issue_idx;
    logic [17:0]        issue_rd;
    logic [IDX_W:0]     occupancy;

    // Producer side: drives instructions, wakeups and stalls
    modport master (
        output alloc_valid, alloc_is_mem, alloc_rd, alloc_src_tag, alloc_src_rdy,
        output wakeup_valid, wakeup_tag, fu_stall,
        input  alloc_ready, issue_valid, issue_idx, issue_rd, occupancy
    );

    // Scheduler side
    modport slave (
        input  alloc_valid, alloc_is_mem, alloc_rd, alloc_src_tag, alloc_src_rdy,
        input  wakeup_valid, wakeup_tag, fu_stall,
        output alloc_ready, issue_valid, issue_idx, issue_rd, occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler: RS_DEPTH-entry reservation station with an
// age matrix, tag-broadcast wakeup and oldest-first select onto two ALUs and
// one pipelined-busy MEM unit. Selection works from registered state only;
// the issue lanes are registered one cycle after select.
module issue_scheduler #(
    parameter int RS_DEPTH = 16,
    parameter int MEM_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    issue_scheduler_if.slave sched_if
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam int TAG_W = 6;
    localparam logic [OCC_W-1:0] ALLOC_LIMIT   = OCC_W'(RS_DEPTH - 2);
    localparam logic [2:0]       MEM_BUSY_INIT = 3'(MEM_LAT - 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Entry storage
    logic [RS_DEPTH-1:0]                   valid_q, valid_d;
    logic [RS_DEPTH-1:0]                   is_mem_q, is_mem_d;
    logic [RS_DEPTH-1:0][TAG_W-1:0]        rd_q, rd_d;
    logic [RS_DEPTH-1:0][1:0][TAG_W-1:0]   src_q, src_d;
    logic [RS_DEPTH-1:0][1:0]              rdy_q, rdy_d;
    // age_q[i][j] = 1 means entry i is older than entry j
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]     age_q, age_d;

    logic [2:0]                            busy_q, busy_d;
    logic [OCC_W-1:0]                      occ_q, occ_d;
    logic [2:0]                            issue_valid_q;
    logic [2:0][IDX_W-1:0]                 issue_idx_q;
    logic [2:0][TAG_W-1:0]                 issue_rd_q;

    // Allocation / selection intermediates
    logic                                  alloc_ready;
    logic [1:0]                            alloc_take;
    logic [OCC_W-1:0]                      free_cnt;
    idx_t                                  free0_idx, free1_idx;
    logic [1:0][IDX_W-1:0]                 slot_idx;
    logic [1:0][RS_DEPTH-1:0]              slot_hit;
    logic [RS_DEPTH-1:0]                   new_mask;
    logic [RS_DEPTH-1:0]                   elig_alu, elig_mem;
    logic [RS_DEPTH-1:0]                   alu_first, alu_second, mem_first;
    logic                                  mem_free;
    logic [2:0][RS_DEPTH-1:0]              gnt;
    logic [RS_DEPTH-1:0]                   issue_mask;
    logic [2:0]                            sel_valid;
    logic [2:0][IDX_W-1:0]                 sel_idx;
    logic [2:0][TAG_W-1:0]                 sel_rd;
    logic [OCC_W-1:0]                      n_alloc, n_issue;

    // True when any unit broadcasts the given tag this cycle
    function automatic logic tag_woken(input tag_t tag, input logic [2:0] wv,
                                       input logic [17:0] wt);
        logic hit;
        hit = 1'b0;
        for (int u = 0; u < 3; u++) begin
            if (wv[u] && (wt[u*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Two free entries are guaranteed whenever alloc_ready is high, so both
    // slots can always be placed; the decision uses registered occupancy only.
    assign alloc_ready = (occ_q <= ALLOC_LIMIT);
    assign alloc_take  = sched_if.alloc_valid & {2{alloc_ready}};

    // Find the two lowest-index free entries. Entries issuing this cycle are
    // still valid_q, so they cannot be handed out until the next cycle.
    always_comb begin
        free_cnt  = '0;
        free0_idx = '0;
        free1_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!valid_q[i]) begin
                if (free_cnt == '0)
                    free0_idx = idx_t'(i);
                else if (free_cnt == OCC_W'(1))
                    free1_idx = idx_t'(i);
                free_cnt = free_cnt + OCC_W'(1);
            end
        end
    end

    // Slot 0 gets the lowest free entry; slot 1 takes the next one only
    // when slot 0 is also allocating, otherwise the lowest.
    always_comb begin
        slot_idx[0] = free0_idx;
        slot_idx[1] = alloc_take[0] ? free1_idx : free0_idx;
    end

    // Per-entry allocation hits, eligibility and age-based ranking
    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
        logic [OCC_W-1:0] alu_older_cnt;
        logic             mem_older;

        assign slot_hit[0][gi] = alloc_take[0] && (slot_idx[0] == idx_t'(gi));
        assign slot_hit[1][gi] = alloc_take[1] && (slot_idx[1] == idx_t'(gi));
        assign elig_alu[gi] = valid_q[gi] & rdy_q[gi][0] & rdy_q[gi][1] & ~is_mem_q[gi];
        assign elig_mem[gi] = valid_q[gi] & rdy_q[gi][0] & rdy_q[gi][1] &  is_mem_q[gi];

        // Count eligible ALU entries older than this one; flag any older MEM entry
        always_comb begin
            alu_older_cnt = '0;
            mem_older     = 1'b0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (elig_alu[j] && age_q[j][gi]) alu_older_cnt = alu_older_cnt + OCC_W'(1);
                if (elig_mem[j] && age_q[j][gi]) mem_older = 1'b1;
            end
        end

        assign alu_first[gi]  = elig_alu[gi] && (alu_older_cnt == '0);
        assign alu_second[gi] = elig_alu[gi] && (alu_older_cnt == OCC_W'(1));
        assign mem_first[gi]  = elig_mem[gi] && !mem_older;
    end

    assign new_mask = slot_hit[0] | slot_hit[1];

    // ALU1 always targets the second-oldest, even if ALU0 is stalled, so the
    // two ALU grants can never name the same entry. ALU and MEM sets are disjoint.
    assign mem_free   = (busy_q == 3'd0) && !sched_if.fu_stall[2];
    assign gnt[0]     = alu_first  & {RS_DEPTH{!sched_if.fu_stall[0]}};
    assign gnt[1]     = alu_second & {RS_DEPTH{!sched_if.fu_stall[1]}};
    assign gnt[2]     = mem_first  & {RS_DEPTH{mem_free}};
    assign issue_mask = gnt[0] | gnt[1] | gnt[2];

    // One-hot grants to index and dest tag; lanes without a grant stay zero
    always_comb begin
        sel_valid = '0;
        sel_idx   = '0;
        sel_rd    = '0;
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (gnt[u][i]) begin
                    sel_valid[u] = 1'b1;
                    sel_idx[u]   = sel_idx[u] | idx_t'(i);
                    sel_rd[u]    = sel_rd[u] | rd_q[i];
                end
            end
        end
    end

    // Entry next state: retire issued entries, capture new ones, apply wakeups
    // to both stored sources and sources arriving this cycle.
    always_comb begin
        valid_d  = (valid_q & ~issue_mask) | new_mask;
        is_mem_d = is_mem_q;
        rd_d     = rd_q;
        src_d    = src_q;
        rdy_d    = rdy_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                rdy_d[i][s] = rdy_q[i][s] |
                              tag_woken(src_q[i][s], sched_if.wakeup_valid, sched_if.wakeup_tag);
            end
            for (int k = 0; k < 2; k++) begin
                if (slot_hit[k][i]) begin
                    is_mem_d[i] = sched_if.alloc_is_mem[k];
                    rd_d[i]     = sched_if.alloc_rd[k*TAG_W +: TAG_W];
                    for (int s = 0; s < 2; s++) begin
                        src_d[i][s] = sched_if.alloc_src_tag[k*2*TAG_W + s*TAG_W +: TAG_W];
                        rdy_d[i][s] = sched_if.alloc_src_rdy[2*k + s] |
                                      tag_woken(sched_if.alloc_src_tag[k*2*TAG_W + s*TAG_W +: TAG_W],
                                                sched_if.wakeup_valid, sched_if.wakeup_tag);
                    end
                end
            end
        end
    end

    // Age update: a new entry is younger than every resident entry; within a
    // same-cycle pair the slot-0 entry is the older one.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (i == j)
                    age_d[i][j] = 1'b0;
                else if (new_mask[i] && new_mask[j])
                    age_d[i][j] = (slot_idx[0] == idx_t'(i));
                else if (new_mask[i])
                    age_d[i][j] = 1'b0;
                else if (new_mask[j])
                    age_d[i][j] = 1'b1;
            end
        end
    end

    // MEM busy countdown and occupancy bookkeeping
    always_comb begin
        if (sel_valid[2])
            busy_d = MEM_BUSY_INIT;
        else if (busy_q != 3'd0)
            busy_d = busy_q - 3'd1;
        else
            busy_d = 3'd0;
        n_alloc = OCC_W'(alloc_take[0]) + OCC_W'(alloc_take[1]);
        n_issue = OCC_W'(sel_valid[0]) + OCC_W'(sel_valid[1]) + OCC_W'(sel_valid[2]);
        occ_d   = occ_q + n_alloc - n_issue;
    end

    // State and registered issue lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            is_mem_q      <= '0;
            rd_q          <= '0;
            src_q         <= '0;
            rdy_q         <= '0;
            age_q         <= '0;
            busy_q        <= '0;
            occ_q         <= '0;
            issue_valid_q <= '0;
            issue_idx_q   <= '0;
            issue_rd_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            is_mem_q      <= is_mem_d;
            rd_q          <= rd_d;
            src_q         <= src_d;
            rdy_q         <= rdy_d;
            age_q         <= age_d;
            busy_q        <= busy_d;
            occ_q         <= occ_d;
            issue_valid_q <= sel_valid;
            issue_idx_q   <= sel_idx;
            issue_rd_q    <= sel_rd;
        end
    end

    assign sched_if.alloc_ready = alloc_ready;
    assign sched_if.issue_valid = issue_valid_q;
    assign sched_if.issue_idx   = issue_idx_q;
    assign sched_if.issue_rd    = issue_rd_q;
    assign sched_if.occupancy   = occ_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hand-computed expectations for reset,
// single/dual ALU issue, MEM busy spacing, wakeup timing, full-queue
// backpressure, asynchronous reset, ALU0 stall and slot placement.
module tb_issue_scheduler;
    localparam int RS_DEPTH = 16;
    localparam int MEM_LAT  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    issue_scheduler_if #(.RS_DEPTH(RS_DEPTH)) bus ();

    issue_scheduler #(.RS_DEPTH(RS_DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-16s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("  ok %-16s = %0d", tag, got);
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_valid   = '0;
        bus.alloc_is_mem  = '0;
        bus.alloc_rd      = '0;
        bus.alloc_src_tag = '0;
        bus.alloc_src_rdy = '0;
        bus.wakeup_valid  = '0;
        bus.wakeup_tag    = '0;
    endtask

    task automatic put_slot(input int k, input logic mem, input logic [5:0] rd,
                            input logic [5:0] s0, input logic [5:0] s1, input logic [1:0] rdy);
        bus.alloc_valid[k]               = 1'b1;
        bus.alloc_is_mem[k]              = mem;
        bus.alloc_rd[k*6 +: 6]           = rd;
        bus.alloc_src_tag[k*12 +: 6]     = s0;
        bus.alloc_src_tag[k*12 + 6 +: 6] = s1;
        bus.alloc_src_rdy[k*2 +: 2]      = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        bus.fu_stall = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst alloc_ready", 32'(bus.alloc_ready), 1);
        check_val("rst occupancy",   32'(bus.occupancy), 0);
        check_val("rst issue_valid", 32'(bus.issue_valid), 0);
        check_val("rst issue_rd",    32'(bus.issue_rd), 0);
        rst_n = 1'b1;
        step();

        // Single ready ALU op, rd=5
        put_slot(0, 1'b0, 6'd5, 6'd1, 6'd2, 2'b11);
        step(); idle_inputs();
        check_val("t1 occ after alloc", 32'(bus.occupancy), 1);
        check_val("t1 no early issue",  32'(bus.issue_valid), 0);
        step();
        check_val("t1 issue_valid", 32'(bus.issue_valid), 1);
        check_val("t1 rd0",         32'(bus.issue_rd[5:0]), 5);
        check_val("t1 idx0",        32'(bus.issue_idx[3:0]), 0);
        check_val("t1 idle lanes",  32'(bus.issue_rd[17:6]), 0);
        check_val("t1 occ after",   32'(bus.occupancy), 0);
        step();
        check_val("t1 issue drops", 32'(bus.issue_valid), 0);

        // rd=7,8 together then rd=9
        put_slot(0, 1'b0, 6'd7, 6'd1, 6'd2, 2'b11);
        put_slot(1, 1'b0, 6'd8, 6'd1, 6'd2, 2'b11);
        step(); idle_inputs();
        put_slot(0, 1'b0, 6'd9, 6'd1, 6'd2, 2'b11);
        check_val("t2 occ 2", 32'(bus.occupancy), 2);
        step(); idle_inputs();
        check_val("t2 issue_valid", 32'(bus.issue_valid), 3);
        check_val("t2 alu0 rd",     32'(bus.issue_rd[5:0]), 7);
        check_val("t2 alu1 rd",     32'(bus.issue_rd[11:6]), 8);
        check_val("t2 alu0 idx",    32'(bus.issue_idx[3:0]), 0);
        check_val("t2 alu1 idx",    32'(bus.issue_idx[7:4]), 1);
        check_val("t2 occ 1",       32'(bus.occupancy), 1);
        step();
        check_val("t2 rd9 valid",   32'(bus.issue_valid), 1);
        check_val("t2 rd9",         32'(bus.issue_rd[5:0]), 9);
        check_val("t2 rd9 idx",     32'(bus.issue_idx[3:0]), 2);
        check_val("t2 occ 0",       32'(bus.occupancy), 0);
        step();

        // Two MEM ops, MEM_LAT=2
        put_slot(0, 1'b1, 6'd20, 6'd1, 6'd2, 2'b11);
        put_slot(1, 1'b1, 6'd21, 6'd1, 6'd2, 2'b11);
        step(); idle_inputs();
        step();
        check_val("t3 mem first",  32'(bus.issue_valid), 4);
        check_val("t3 mem rd20",   32'(bus.issue_rd[17:12]), 20);
        check_val("t3 mem idx0",   32'(bus.issue_idx[11:8]), 0);
        step();
        check_val("t3 mem busy",   32'(bus.issue_valid), 0);
        step();
        check_val("t3 mem second", 32'(bus.issue_valid), 4);
        check_val("t3 mem rd21",   32'(bus.issue_rd[17:12]), 21);
        check_val("t3 mem idx1",   32'(bus.issue_idx[11:8]), 1);
        step();
        check_val("t3 occ 0",      32'(bus.occupancy), 0);

        // Entry waits on tag 12; wrong tag first
        put_slot(0, 1'b0, 6'd30, 6'd12, 6'd3, 2'b10);
        step(); idle_inputs();
        bus.wakeup_valid = 3'b010; bus.wakeup_tag[11:6] = 6'd13;
        step(); idle_inputs();
        check_val("t4 wrong tag a", 32'(bus.issue_valid), 0);
        step();
        check_val("t4 wrong tag b", 32'(bus.issue_valid), 0);
        bus.wakeup_valid = 3'b010; bus.wakeup_tag[11:6] = 6'd12;
        step(); idle_inputs();
        check_val("t4 wake N+1",    32'(bus.issue_valid), 0);
        step();
        check_val("t4 wake N+2",    32'(bus.issue_valid), 1);
        check_val("t4 rd30",        32'(bus.issue_rd[5:0]), 30);
        step();

        // Wakeup in the same cycle as allocation
        put_slot(0, 1'b0, 6'd31, 6'd40, 6'd3, 2'b10);
        bus.wakeup_valid = 3'b100; bus.wakeup_tag[17:12] = 6'd40;
        step(); idle_inputs();
        check_val("t4b early",      32'(bus.issue_valid), 0);
        step();
        check_val("t4b issue",      32'(bus.issue_valid), 1);
        check_val("t4b rd31",       32'(bus.issue_rd[5:0]), 31);
        step();

        // Fill to 15 with blocked ops
        for (int p = 0; p < 7; p++) begin
            put_slot(0, 1'b0, 6'(2*p),     6'd50, 6'd50, 2'b00);
            put_slot(1, 1'b0, 6'(2*p + 1), 6'd50, 6'd50, 2'b00);
            step();
        end
        idle_inputs();
        check_val("t5 occ 14",         32'(bus.occupancy), 14);
        check_val("t5 ready at 14",    32'(bus.alloc_ready), 1);
        put_slot(0, 1'b0, 6'd45, 6'd51, 6'd51, 2'b00);
        step(); idle_inputs();
        check_val("t5 occ 15",         32'(bus.occupancy), 15);
        check_val("t5 not ready",      32'(bus.alloc_ready), 0);
        put_slot(0, 1'b0, 6'd46, 6'd1, 6'd1, 2'b11);
        put_slot(1, 1'b0, 6'd47, 6'd1, 6'd1, 2'b11);
        step();
        check_val("t5 ignored occ a",  32'(bus.occupancy), 15);
        step(); idle_inputs();
        check_val("t5 ignored occ b",  32'(bus.occupancy), 15);
        check_val("t5 ignored no iss", 32'(bus.issue_valid), 0);
        bus.wakeup_valid = 3'b001; bus.wakeup_tag[5:0] = 6'd51;
        step(); idle_inputs();
        check_val("t5 occ hold",       32'(bus.occupancy), 15);
        step();
        check_val("t5 issue",          32'(bus.issue_valid), 1);
        check_val("t5 rd45",           32'(bus.issue_rd[5:0]), 45);
        check_val("t5 idx14",          32'(bus.issue_idx[3:0]), 14);
        check_val("t5 occ 14 again",   32'(bus.occupancy), 14);
        check_val("t5 ready again",    32'(bus.alloc_ready), 1);

        // Asynchronous reset with 14 entries pending
        rst_n = 1'b0;
        #1;
        check_val("t6 async occ",      32'(bus.occupancy), 0);
        check_val("t6 async ready",    32'(bus.alloc_ready), 1);
        check_val("t6 async iv",       32'(bus.issue_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.wakeup_valid = 3'b001; bus.wakeup_tag[5:0] = 6'd50;
        step(); idle_inputs();
        check_val("t6 post rst iv a",  32'(bus.issue_valid), 0);
        step();
        check_val("t6 post rst iv b",  32'(bus.issue_valid), 0);
        check_val("t6 post rst occ",   32'(bus.occupancy), 0);

        // ALU0 stalled: ALU1 takes the second-oldest
        bus.fu_stall = 3'b001;
        put_slot(0, 1'b0, 6'd40, 6'd1, 6'd2, 2'b11);
        put_slot(1, 1'b0, 6'd41, 6'd1, 6'd2, 2'b11);
        step(); idle_inputs();
        step();
        check_val("t7 alu1 only",      32'(bus.issue_valid), 2);
        check_val("t7 alu1 rd41",      32'(bus.issue_rd[11:6]), 41);
        check_val("t7 alu1 idx1",      32'(bus.issue_idx[7:4]), 1);
        check_val("t7 alu0 rd zero",   32'(bus.issue_rd[5:0]), 0);
        bus.fu_stall = 3'b000;
        step();
        check_val("t7 alu0 after",     32'(bus.issue_valid), 1);
        check_val("t7 alu0 rd40",      32'(bus.issue_rd[5:0]), 40);
        check_val("t7 alu0 idx0",      32'(bus.issue_idx[3:0]), 0);
        step();
        check_val("t7 occ 0",          32'(bus.occupancy), 0);

        // Slot 1 alone lands in the lowest free entry
        put_slot(1, 1'b0, 6'd55, 6'd1, 6'd2, 2'b11);
        step(); idle_inputs();
        step();
        check_val("t8 slot1 iv",       32'(bus.issue_valid), 1);
        check_val("t8 slot1 rd",       32'(bus.issue_rd[5:0]), 55);
        check_val("t8 slot1 idx",      32'(bus.issue_idx[3:0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter RS_DEPTH, default 16, number of scheduler entries (power of two, 4..32).
REQ-002 Parameter MEM_LAT, default 2, cycles the MEM unit stays busy per issued op (1..7).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 alloc_valid  in  2  bit k = renamed instruction in slot k (slot 0 older).
REQ-006 alloc_is_mem  in  2  bit k = slot k is load/store (MEM unit), else ALU.
REQ-007 alloc_rd  in  12  physical dest tag, slot k in bits [6k+5:6k].
REQ-008 alloc_src_tag  in  24  source tags, slot k src s in bits [12k+6s+5:12k+6s].
REQ-009 alloc_src_rdy  in  4  bit 2k+s = slot k source s already available.
REQ-010 alloc_ready  out  1  scheduler can accept two instructions this cycle.
REQ-011 wakeup_valid  in  3  completion broadcast valid, one per unit (ALU0, ALU1, MEM).
REQ-012 wakeup_tag  in  18  completed physical tag, unit u in bits [6u+5:6u].
REQ-013 fu_stall  in  3  unit u cannot accept an op this cycle.
REQ-014 issue_valid  out  3  registered; op issued to unit u (0=ALU0, 1=ALU1, 2=MEM).
REQ-015 issue_idx  out  3*log2(RS_DEPTH)  entry index issued to unit u.
REQ-016 issue_rd  out  18  dest tag of op issued to unit u.
REQ-017 occupancy  out  log2(RS_DEPTH)+1  registered count of valid entries.

Function
REQ-018 Each entry SHALL hold valid, is_mem, rd, two src tags, two ready bits; age SHALL be an RS_DEPTH x RS_DEPTH age matrix.
REQ-019 alloc_ready SHALL be 1 iff occupancy <= RS_DEPTH-2, derived from registered state only.
REQ-020 alloc_valid bits with alloc_ready=0 SHALL be ignored with no state change.
REQ-021 Accepted slots SHALL write the lowest-index free entries, slot 0 to the lower index; slot 1 alone SHALL use the lowest free index.
REQ-022 Entry i SHALL be older than j if allocated in an earlier cycle, or the same cycle from slot 0.
REQ-023 Entries freed by issue in cycle N SHALL NOT be reallocated before cycle N+1.
REQ-024 A src ready bit SHALL set when any wakeup_valid[u] has wakeup_tag[u] equal to that src tag; applies to stored entries and same-cycle allocations.
REQ-025 Selection SHALL use registered ready bits: wakeup in cycle N makes an entry eligible for selection in cycle N+1, issue_valid visible N+2.
REQ-026 ALU0 SHALL take the oldest eligible non-mem entry; ALU1 the second-oldest; MEM the oldest eligible mem entry.
REQ-027 Eligible = valid and both ready bits set; fu_stall[u]=1 or MEM busy SHALL suppress unit u only, the skipped entry remaining for later.
REQ-028 When ALU0 is stalled, ALU1 SHALL still take the second-oldest, not the oldest.
REQ-029 An entry issued in cycle N SHALL be invalid from cycle N+1; issue_valid/idx/rd SHALL be registered (1-cycle select-to-output latency).
REQ-030 MEM issue SHALL load a busy counter with MEM_LAT-1; MEM SHALL be ineligible while counter != 0; counter decrements each cycle.
REQ-031 occupancy SHALL update by +accepted allocations -issues each cycle, never exceed RS_DEPTH, never underflow.
REQ-032 No entry SHALL issue to two units in the same cycle.
REQ-033 issue_idx/issue_rd SHALL be 0 when the matching issue_valid is 0.

Reset
REQ-034 rst_n=0 SHALL asynchronously clear all entry valid/ready bits, age matrix, busy counter, issue_valid, issue_idx, issue_rd, occupancy; alloc_ready SHALL read 1.
REQ-035 Reset asserted mid-operation SHALL discard all pending entries; no issue_valid in the first cycle after deassertion.

Verification
REQ-036 Reset, allocate slot0 ALU rd=5 srcs ready -> entry 0, issue_valid=3'b001, issue_rd[5:0]=5 two cycles after alloc; occupancy 1 then 0.
REQ-037 Allocate 3 ready ALU ops rd=7,8,9 (7,8 same cycle, 9 next) -> ALU0 rd=7, ALU1 rd=8 same cycle, rd=9 ALU0 one cycle later.
REQ-038 Two ready MEM ops, MEM_LAT=2 -> MEM issues on cycles N and N+2, none on N+1.
REQ-039 Entry waiting on tag 12; wakeup_valid[1]=1 tag 12 at cycle N -> issue_valid seen N+2; wrong tag 13 -> no issue.
REQ-040 Fill to occupancy 15 -> alloc_ready=0, further alloc_valid=2'b11 ignored, occupancy stays 15 until an issue.
REQ-041 fu_stall=3'b001 with 2 ready ALU ops -> only ALU1 issues, takes second-oldest; oldest issues on ALU0 after stall drops.
